// File: rtl/vc_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_pop_arbiter
// Purpose  : Pops VC0/VC1 FIFOs and routes each word to D0/D1 by its dest bit.
//            Define VC_ROUND_ROBIN_EN for alternating VC grants.
// Revision : 1.0  initial release
// ============================================================================
module vc_pop_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int DEST_BIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init_i,
   input  logic                  vc0_empty_i,
   input  logic                  vc1_empty_i,
   input  logic [DATA_WIDTH-1:0] vc0_data_i,
   input  logic [DATA_WIDTH-1:0] vc1_data_i,
   input  logic                  d0_almost_full_i,
   input  logic                  d1_almost_full_i,
   output logic                  vc0_rd_enable_o,
   output logic                  vc1_rd_enable_o,
   output logic                  d0_push_o,
   output logic [DATA_WIDTH-1:0] d0_data_o,
   output logic                  d1_push_o,
   output logic [DATA_WIDTH-1:0] d1_data_o,
   output logic [1:0]            state_o,
   output logic                  idle_o
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'b00,
      ST_INIT   = 2'b01,
      ST_IDLE   = 2'b10,
      ST_ACTIVE = 2'b11
   } state_t;

   state_t                  state_q, state_d;
   logic                    p_valid_q;
   logic                    p_sel_q;
   logic                    d0_push_q, d1_push_q;
   logic [DATA_WIDTH-1:0]   d0_data_q, d1_data_q;

   logic                    w_stall;
   logic                    w_run;
   logic                    w_rd0, w_rd1;
   logic                    w_pop;
   logic [DATA_WIDTH-1:0]   w_word;
   logic                    w_dest;

   // Destination is unknown until the word is read, so either flag blocks pops
   assign w_stall = d0_almost_full_i | d1_almost_full_i;
   assign w_run   = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                    init_i && reset && !w_stall;

`ifdef VC_ROUND_ROBIN_EN
   logic last_grant_q;
   logic w_pick1;

   always_comb begin
      w_pick1 = vc0_empty_i;
      if (!vc0_empty_i && !vc1_empty_i) begin
         w_pick1 = ~last_grant_q;
      end
   end

   assign w_rd0 = w_run & ~w_pick1 & ~vc0_empty_i;
   assign w_rd1 = w_run &  w_pick1 & ~vc1_empty_i;

   // Reset to 1 so VC0 wins the first contended grant
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant_q <= 1'b1;
      end else if (w_rd0 || w_rd1) begin
         last_grant_q <= w_rd1;
      end
   end
`else
   assign w_rd0 = w_run & ~vc0_empty_i;
   assign w_rd1 = w_run &  vc0_empty_i & ~vc1_empty_i;
`endif

   assign w_pop  = w_rd0 | w_rd1;
   assign w_word = p_sel_q ? vc1_data_i : vc0_data_i;
   assign w_dest = w_word[DEST_BIT];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT:  if (init_i) state_d = ST_IDLE;
         default: begin
            if (!init_i)    state_d = ST_INIT;
            else if (w_pop) state_d = ST_ACTIVE;
            else            state_d = ST_IDLE;
         end
      endcase
   end

   // A word already in flight completes even if init drops; only reset drops it
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_RESET;
         p_valid_q <= 1'b0;
         p_sel_q   <= 1'b0;
         d0_push_q <= 1'b0;
         d1_push_q <= 1'b0;
         d0_data_q <= '0;
         d1_data_q <= '0;
      end else begin
         state_q   <= state_d;
         p_valid_q <= w_pop;
         p_sel_q   <= w_rd1;
         d0_push_q <= p_valid_q & ~w_dest;
         d1_push_q <= p_valid_q &  w_dest;
         if (p_valid_q && !w_dest) d0_data_q <= w_word;
         if (p_valid_q &&  w_dest) d1_data_q <= w_word;
      end
   end

   assign vc0_rd_enable_o = w_rd0;
   assign vc1_rd_enable_o = w_rd1;
   assign d0_push_o       = d0_push_q;
   assign d1_push_o       = d1_push_q;
   assign d0_data_o       = d0_data_q;
   assign d1_data_o       = d1_data_q;
   assign state_o         = state_q;
   assign idle_o          = (state_q == ST_IDLE) & ~p_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_pop_arbiter
// Purpose  : Directed bench for vc_pop_arbiter with VC FIFO models and a
//            push scoreboard. Revision 1.0
// ============================================================================
module tb_vc_pop_arbiter;

   logic       clk;
   logic       reset;
   logic       init;
   logic       vc0_empty, vc1_empty;
   logic [5:0] vc0_data, vc1_data;
   logic       d0_af, d1_af;
   logic       vc0_rd, vc1_rd;
   logic       d0_push, d1_push;
   logic [5:0] d0_data, d1_data;
   logic [1:0] state;
   logic       idle;

   vc_pop_arbiter #(.DATA_WIDTH(6), .DEST_BIT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .init_i           (init),
      .vc0_empty_i      (vc0_empty),
      .vc1_empty_i      (vc1_empty),
      .vc0_data_i       (vc0_data),
      .vc1_data_i       (vc1_data),
      .d0_almost_full_i (d0_af),
      .d1_almost_full_i (d1_af),
      .vc0_rd_enable_o  (vc0_rd),
      .vc1_rd_enable_o  (vc1_rd),
      .d0_push_o        (d0_push),
      .d0_data_o        (d0_data),
      .d1_push_o        (d1_push),
      .d1_data_o        (d1_data),
      .state_o          (state),
      .idle_o           (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int         due;
      logic       dest;
      logic [5:0] data;
   } ent_t;

   ent_t       sb[$];
   logic [5:0] vc0_fifo[$];
   logic [5:0] vc1_fifo[$];
   int         grants[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   int         cyc    = 0;
   logic [5:0] last_d0 = 6'h00;
   logic [5:0] last_d1 = 6'h00;

   // Snapshot of DUT outputs at the most recent negedge
   logic       s_rd0, s_rd1, s_p0, s_p1, s_idle;
   logic [1:0] s_state;
   logic [5:0] s_d0, s_d1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic update_flags();
      vc0_empty = (vc0_fifo.size() == 0);
      vc1_empty = (vc1_fifo.size() == 0);
   endtask

   task automatic cycle();
      ent_t e;
      logic rst_edge;
      @(negedge clk);
      cyc++;
      s_rd0 = vc0_rd;   s_rd1 = vc1_rd;
      s_p0  = d0_push;  s_p1  = d1_push;
      s_d0  = d0_data;  s_d1  = d1_data;
      s_state = state;  s_idle = idle;

      check("rd_onehot", {31'd0, s_rd0 & s_rd1}, 32'd0);
      if (s_rd0) check("rd0_on_empty", {31'd0, vc0_empty}, 32'd0);
      if (s_rd1) check("rd1_on_empty", {31'd0, vc1_empty}, 32'd0);

      if (s_p0 || s_p1) begin
         if (sb.size() == 0) begin
            check("push_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("push_onehot", {31'd0, s_p0 & s_p1}, 32'd0);
            check("push_cycle", cyc, e.due);
            check("push_dest", {31'd0, s_p1}, {31'd0, e.dest});
            check("push_data", {26'd0, (s_p1 ? s_d1 : s_d0)}, {26'd0, e.data});
            if (e.dest) last_d1 = e.data; else last_d0 = e.data;
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check("push_missing", 32'd0, 32'd1);
      end
      if (!s_p0) check("d0_hold", {26'd0, s_d0}, {26'd0, last_d0});
      if (!s_p1) check("d1_hold", {26'd0, s_d1}, {26'd0, last_d1});

      if (s_rd0 && vc0_fifo.size() > 0) begin
         e.due = cyc + 2; e.data = vc0_fifo[0]; e.dest = e.data[4];
         sb.push_back(e);
         grants.push_back(0);
      end
      if (s_rd1 && vc1_fifo.size() > 0) begin
         e.due = cyc + 2; e.data = vc1_fifo[0]; e.dest = e.data[4];
         sb.push_back(e);
         grants.push_back(1);
      end
      rst_edge = !reset;

      @(posedge clk);
      #1;
      if (s_rd0 && vc0_fifo.size() > 0) vc0_data = vc0_fifo.pop_front();
      else                              vc0_data = 6'h00;
      if (s_rd1 && vc1_fifo.size() > 0) vc1_data = vc1_fifo.pop_front();
      else                              vc1_data = 6'h00;
      update_flags();
      if (rst_edge) begin
         sb.delete();
         last_d0 = 6'h00;
         last_d1 = 6'h00;
      end
   endtask

   task automatic reset_and_init();
      reset = 1'b0;
      cycle(); cycle();
      reset = 1'b1;
      init  = 1'b1;
      cycle(); cycle(); cycle();
      check("reinit_state", {30'd0, s_state}, 32'd2);
   endtask

   int exp_grants[6];
   int stall_pushes;

   initial begin
      reset = 1'b0; init = 1'b0;
      d0_af = 1'b0; d1_af = 1'b0;
      vc0_data = 6'h00; vc1_data = 6'h00;
      update_flags();

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("rst_state", {30'd0, s_state}, 32'd0);
         check("rst_push", {30'd0, s_p0, s_p1}, 32'd0);
         check("rst_rd", {30'd0, s_rd0, s_rd1}, 32'd0);
         check("rst_idle", {31'd0, s_idle}, 32'd0);
      end

      // Release reset with init low: RESET then INIT
      reset = 1'b1;
      cycle();
      check("rel_state0", {30'd0, s_state}, 32'd0);
      cycle();
      check("rel_state1", {30'd0, s_state}, 32'd1);
      cycle();
      check("init_hold_state", {30'd0, s_state}, 32'd1);
      check("init_hold_rd", {30'd0, s_rd0, s_rd1}, 32'd0);

      init = 1'b1;
      cycle();
      check("init_state", {30'd0, s_state}, 32'd1);
      cycle();
      check("idle_state", {30'd0, s_state}, 32'd2);
      check("idle_flag", {31'd0, s_idle}, 32'd1);

      // Two words on VC0, dest D1 then D0
      vc0_fifo.push_back(6'h15); vc0_fifo.push_back(6'h05); update_flags();
      cycle(); check("two_rd_a", {31'd0, s_rd0}, 32'd1);
      cycle(); check("two_rd_b", {31'd0, s_rd0}, 32'd1);
               check("two_active", {30'd0, s_state}, 32'd3);
      cycle(); check("two_rd_c", {31'd0, s_rd0}, 32'd0);
               check("two_p1", {31'd0, s_p1}, 32'd1);
               check("two_d1", {26'd0, s_d1}, 32'h15);
      cycle(); check("two_p0", {31'd0, s_p0}, 32'd1);
               check("two_d0", {26'd0, s_d0}, 32'h05);
               check("two_back_idle", {30'd0, s_state}, 32'd2);
      cycle(); check("two_idle_flag", {31'd0, s_idle}, 32'd1);

      // Both VCs loaded with 3 words each
      reset_and_init();
      grants.delete();
      vc0_fifo.push_back(6'h01); vc0_fifo.push_back(6'h12); vc0_fifo.push_back(6'h03);
      vc1_fifo.push_back(6'h21); vc1_fifo.push_back(6'h32); vc1_fifo.push_back(6'h23);
      update_flags();
      for (int i = 0; i < 9; i++) cycle();
`ifdef VC_ROUND_ROBIN_EN
      exp_grants = '{0, 1, 0, 1, 0, 1};
`else
      exp_grants = '{0, 0, 0, 1, 1, 1};
`endif
      check("grant_count", grants.size(), 32'd6);
      for (int i = 0; i < 6 && i < grants.size(); i++)
         check($sformatf("grant_%0d", i), grants[i], exp_grants[i]);

      // Almost-full raised mid-stream
      vc0_fifo = '{6'h12, 6'h04, 6'h13, 6'h05, 6'h16, 6'h07}; update_flags();
      cycle(); check("af_rd1", {31'd0, s_rd0}, 32'd1);
      cycle(); check("af_rd2", {31'd0, s_rd0}, 32'd1);
      d0_af = 1'b1;
      cycle(); check("af_stop", {31'd0, s_rd0}, 32'd0);
      stall_pushes = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("af_hold_rd", {30'd0, s_rd0, s_rd1}, 32'd0);
         if (s_p0 || s_p1) stall_pushes++;
      end
      check("af_inflight", stall_pushes, 32'd1);
      d0_af = 1'b0;
      cycle(); check("af_resume", {31'd0, s_rd0}, 32'd1);
      for (int i = 0; i < 6; i++) cycle();
      check("af_drained", vc0_fifo.size(), 32'd0);
      check("af_idle", {30'd0, s_state}, 32'd2);

      // init dropped with a pop in flight
      vc0_fifo.push_back(6'h18); vc0_fifo.push_back(6'h09); update_flags();
      cycle(); check("id_rd", {31'd0, s_rd0}, 32'd1);
      init = 1'b0;
      cycle(); check("id_no_rd", {31'd0, s_rd0}, 32'd0);
               check("id_active", {30'd0, s_state}, 32'd3);
      cycle(); check("id_push", {31'd0, s_p1}, 32'd1);
               check("id_state", {30'd0, s_state}, 32'd1);
      cycle(); check("id_no_rd2", {30'd0, s_rd0, s_rd1}, 32'd0);
      check("id_left", vc0_fifo.size(), 32'd1);

      // Reset with a pop in flight
      init = 1'b1;
      cycle(); check("rr_init", {30'd0, s_state}, 32'd1);
      cycle(); check("rr_rd", {31'd0, s_rd0}, 32'd1);
      reset = 1'b0;
      cycle(); check("rr_rd_off", {31'd0, s_rd0}, 32'd0);
      cycle(); check("rr_state", {30'd0, s_state}, 32'd0);
               check("rr_push", {30'd0, s_p0, s_p1}, 32'd0);
               check("rr_data", {20'd0, s_d0, s_d1}, 32'd0);
               check("rr_idle", {31'd0, s_idle}, 32'd0);
      reset = 1'b1;
      cycle();
      check("sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
